// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response pair.
// Byte/half/word loads and stores with a programmable response latency.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // With zero latency the response is formed on the accepting edge, so the
  // operation is taken straight from the request pins in IDLE.
  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_size;
  logic        op_unsigned;

  assign op_write    = (state == IDLE) ? req_write    : r_write;
  assign op_addr     = (state == IDLE) ? req_addr     : r_addr;
  assign op_wdata    = (state == IDLE) ? req_wdata    : r_wdata;
  assign op_size     = (state == IDLE) ? req_size     : r_size;
  assign op_unsigned = (state == IDLE) ? req_unsigned : r_unsigned;

  logic          op_err;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [4:0]    lane_shift;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shifted;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_shifted;
  logic [31:0]   merged;
  logic          enter_resp;

  assign widx       = op_addr[AW+1:2];
  assign lane       = op_addr[1:0];
  assign lane_shift = {lane, 3'b000};
  assign rd_word    = mem[widx];
  assign rd_shifted = rd_word >> lane_shift;
  assign wr_shifted = op_wdata << lane_shift;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op_err = 1'b0;
    case (op_size)
      SIZE_BYTE: op_err = 1'b0;
      SIZE_HALF: op_err = op_addr[0];
      SIZE_WORD: op_err = |op_addr[1:0];
      default:   op_err = 1'b1;
    endcase
    if (op_addr >= LIMIT) op_err = 1'b1;
  end

  always_comb begin
    load_data = rd_shifted;
    byte_en   = 4'b1111;
    case (op_size)
      SIZE_BYTE: begin
        load_data = {{24{~op_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
        byte_en   = 4'b0001 << lane;
      end
      SIZE_HALF: begin
        load_data = {{16{~op_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
        byte_en   = 4'b0011 << lane;
      end
      default: begin
        load_data = rd_shifted;
        byte_en   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = wr_shifted[8*b +: 8];
    end
  end

  // The counter runs LATENCY down to zero and spends one more cycle at zero,
  // which places the response LATENCY+1 edges after acceptance.
  assign enter_resp = ((state == IDLE) && req_valid && (LAT == 4'd0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            if (LAT == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (op_write || op_err) ? 32'd0 : load_data;
      err_q   <= op_err;
    end
  end

  // NOTE: the storage is cleared by reset, so it is built from resettable
  // flops rather than a RAM macro; the clear loop is part of the reset branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && op_write && !op_err) begin
      mem[widx] <= merged;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at DEPTH=256, LATENCY=2.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request from a post-edge point, consumes the response and
  // returns data, error and edges from accept to resp_valid.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u,
                      output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a;
    req_wdata = wd; req_size = sz; req_unsigned = u;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF; req_size = 2'b11; req_unsigned = ~u;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL xact_timeout addr=%h: resp_valid=%b required 1", a, resp_valid);
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'h5555_5555; req_size = 2'b10; req_unsigned = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    req_valid = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL word_store: rdata=%h err=%b lat=%0d required 00000000 0 3", rd, er, lat);
    end
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL word_load: rdata=%h err=%b lat=%0d required deadbeef 0 3", rd, er, lat);
    end
    xact(1'b1, 32'h3FC, 32'hCAFE_F00D, 2'b10, 1'b0, rd, er, lat);
    xact(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b1, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      errors++;
      $display("FAIL top_word_load: rdata=%h err=%b required cafef00d 0", rd, er);
    end
  endtask

  task automatic test_extend;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_v [5];
    logic [31:0] addr_v [5];
    logic [1:0]  size_v [5];
    logic        uns_v [5];
    exp_v  = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0, 32'hFFFF_FF80};
    addr_v = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h21};
    size_v = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    uns_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    xact(1'b1, 32'h20, 32'h0000_80F0, 2'b10, 1'b0, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      xact(1'b0, addr_v[i], 32'h0, size_v[i], uns_v[i], rd, er, lat);
      checks++;
      if (rd !== exp_v[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL extend_%0d: rdata=%h err=%b required %h 0", i, rd, er, exp_v[i]);
      end
    end
  endtask

  task automatic test_partial;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h40, 32'h1122_3344, 2'b10, 1'b0, rd, er, lat);
    xact(1'b1, 32'h42, 32'hFFFF_FFAA, 2'b00, 1'b0, rd, er, lat);
    xact(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AA_3344 || er !== 1'b0) begin
      errors++;
      $display("FAIL partial_byte: rdata=%h err=%b required 11aa3344 0", rd, er);
    end
    xact(1'b1, 32'h40, 32'h1234_BEEF, 2'b01, 1'b0, rd, er, lat);
    xact(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_11AA || er !== 1'b0) begin
      errors++;
      $display("FAIL partial_half_upper: rdata=%h err=%b required 000011aa 0", rd, er);
    end
    xact(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AA_BEEF) begin
      errors++;
      $display("FAIL partial_half_word: rdata=%h required 11aabeef", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 32'h42, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL err_misaligned_word: rdata=%h err=%b lat=%0d required 00000000 1 3", rd, er, lat);
    end
    xact(1'b1, 32'h11, 32'h0000_7777, 2'b01, 1'b0, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_misaligned_half: err=%b required 1", er);
    end
    xact(1'b1, 32'h400, 32'h9999_9999, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL err_range_store: rdata=%h err=%b required 00000000 1", rd, er);
    end
    xact(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_range_word0: rdata=%h err=%b required 00000000 0", rd, er);
    end
    xact(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL err_range_top: rdata=%h required cafef00d", rd);
    end
    xact(1'b1, 32'h10, 32'h0BAD_0BAD, 2'b11, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL err_size11_store: rdata=%h err=%b required 00000000 1", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL err_size11_load: rdata=%h err=%b required 00000000 1", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL err_mem_unchanged: rdata=%h err=%b required deadbeef 0", rd, er);
    end
  endtask

  // Holds the response for five cycles with a competing request pending,
  // then checks the pending request is taken one edge after the consume edge.
  task automatic test_back_to_back;
    int lat;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_addr = 32'h10;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_latency: lat=%0d valid=%b required 3 1", lat, resp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'h11AA_BEEF
          || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b rdata=%h err=%b required 1 0 11aabeef 0",
                 i, resp_valid, req_ready, resp_rdata, resp_err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consume_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: ready=%b required 0", req_ready);
    end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3 || resp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bp_next_resp: lat=%0d rdata=%h required 3 deadbeef", lat, resp_rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er; int lat;
    // resp_rdata still holds deadbeef from the last load going into this test
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8;
    req_wdata = 32'h1234_5678; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs: ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resp: valid=%b required 0", resp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_store_dropped: rdata=%h err=%b required 00000000 0", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL abort_mem_cleared: rdata=%h required 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
